// File: rtl/qmeas_pkg.sv
// Shared types and helpers for the charge-measurement front end.
// Provides the FSM state encoding and the APPLY-to-ready latency formula.
package qmeas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_SAMPLE,
      ST_CONVERT,
      ST_ACCUM,
      ST_DONE
   } state_t;

   // Cycles from entering APPLY through the DONE cycle, inclusive.
   function automatic int meas_latency(
      input int bus_width,
      input int settle_cycles,
      input int avg_log2
   );
      return 1 + settle_cycles + (1 << avg_log2) * (bus_width + 2) + 1;
   endfunction

endpackage

// File: rtl/qmeas_frontend_sar_core.sv
// Successive-approximation register: one-hot bit pointer walking MSB to LSB.
// Ports: clk, rst (sync, active-high), start (load MSB trial), cmp_in
//        (1 = held input >= trial) -> trial (comparator DAC code),
//        done (high during the LSB step), result (final code, held).
module sar_core #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_in,
   output logic [WIDTH-1:0] trial,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

   logic [WIDTH-1:0] r_ptr;
   logic [WIDTH-1:0] r_trial;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_keep;

   // Resolve the bit under test: keep it only if the comparator says
   // the held input is at or above the trial code.
   always_comb begin
      w_keep = cmp_in ? r_trial : (r_trial & ~r_ptr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr    <= '0;
         r_trial  <= '0;
         r_result <= '0;
      end else if (start) begin
         r_ptr   <= MSB;
         r_trial <= MSB;
      end else if (|r_ptr) begin
         r_ptr   <= r_ptr >> 1;
         r_trial <= w_keep | (r_ptr >> 1);
         if (r_ptr[0]) begin
            r_result <= w_keep;
         end
      end
   end

   assign trial  = r_trial;
   assign done   = r_ptr[0];
   assign result = r_result;

endmodule

// File: rtl/qmeas_frontend.sv
// Measurement responder: latches i_ref onto the current DAC, waits to
// settle, averages 2**AVG_LOG2 SAR conversions and pulses ready.
// Ports: clk, rst (sync, active-high), en (run measurements),
//        i_ref (reference code), cmp_in (SAR comparator) ->
//        dac_drive, sar_dac, sample (1 = track), q_measured, ready.
module qmeas_frontend
   import qmeas_pkg::*;
#(
   parameter int BUS_WIDTH     = 10,
   parameter int SETTLE_CYCLES = 16,
   parameter int AVG_LOG2      = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic                 cmp_in,
   output logic [BUS_WIDTH-1:0] dac_drive,
   output logic [BUS_WIDTH-1:0] sar_dac,
   output logic                 sample,
   output logic [BUS_WIDTH-1:0] q_measured,
   output logic                 ready
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int CW = AVG_LOG2 + 1;
   localparam int AW = BUS_WIDTH + AVG_LOG2;

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CONV_LAST   = CW'((1 << AVG_LOG2) - 1);

   state_t               r_state;
   logic [SW-1:0]        r_settle_cnt;
   logic [CW-1:0]        r_conv_cnt;
   logic [AW-1:0]        r_acc;
   logic [BUS_WIDTH-1:0] r_dac_drive;
   logic                 r_sample;
   logic [BUS_WIDTH-1:0] r_q;
   logic                 r_ready;

   logic                 w_sar_start;
   logic                 w_sar_done;
   logic [BUS_WIDTH-1:0] w_sar_result;
   logic [AW-1:0]        w_acc_next;

   // The SAR loads its MSB trial on the edge that leaves SAMPLE.
   assign w_sar_start = (r_state == ST_SAMPLE);
   assign w_acc_next  = r_acc + AW'(w_sar_result);

   sar_core #(
      .WIDTH (BUS_WIDTH)
   ) u_sar (
      .clk    (clk),
      .rst    (rst),
      .start  (w_sar_start),
      .cmp_in (cmp_in),
      .trial  (sar_dac),
      .done   (w_sar_done),
      .result (w_sar_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_conv_cnt   <= '0;
         r_acc        <= '0;
         r_dac_drive  <= '0;
         r_sample     <= 1'b0;
         r_q          <= '0;
         r_ready      <= 1'b0;
      end else begin
         r_sample <= 1'b0;
         r_ready  <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (en) begin
                  r_state <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               r_dac_drive  <= i_ref;
               r_settle_cnt <= '0;
               r_state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_sample <= 1'b1;
                  r_state  <= ST_SAMPLE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
               r_state <= ST_CONVERT;
            end
            ST_CONVERT: begin
               // done marks the LSB step; the result register is
               // final from the next cycle on.
               if (w_sar_done) begin
                  r_state <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               r_acc <= w_acc_next;
               if (r_conv_cnt == CONV_LAST) begin
                  // Publish the average as DONE is entered so that
                  // q_measured is already valid while ready is high.
                  r_q     <= w_acc_next[AW-1:AVG_LOG2];
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_conv_cnt <= r_conv_cnt + 1'b1;
                  r_sample   <= 1'b1;
                  r_state    <= ST_SAMPLE;
               end
            end
            ST_DONE: begin
               r_acc      <= '0;
               r_conv_cnt <= '0;
               r_state    <= en ? ST_APPLY : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dac_drive  = r_dac_drive;
   assign sample     = r_sample;
   assign q_measured = r_q;
   assign ready      = r_ready;

endmodule

// File: tb/tb_qmeas_frontend.sv
// Scoreboard bench for qmeas_frontend with a comparator/plant model
// and a secant controller closing the loop on q_measured.
module tb_qmeas_frontend;
   import qmeas_pkg::*;

   localparam int BW = 10;
   localparam int ST = 16;
   localparam int AL = 2;

   localparam int M_LEVEL = 0;
   localparam int M_RAMP  = 1;
   localparam int M_ONE   = 2;
   localparam int M_ZERO  = 3;
   localparam int M_PLANT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [BW-1:0] i_ref;
   logic          cmp_in;
   logic [BW-1:0] dac_drive;
   logic [BW-1:0] sar_dac;
   logic          sample;
   logic [BW-1:0] q_measured;
   logic          ready;

   int n_vec = 0;
   int n_bad = 0;
   int sb[$];

   int            mode = M_LEVEL;
   int            lvl  = 0;
   int            idx;
   logic [BW-1:0] held;

   always #5 clk = ~clk;

   qmeas_frontend #(
      .BUS_WIDTH     (BW),
      .SETTLE_CYCLES (ST),
      .AVG_LOG2      (AL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .i_ref      (i_ref),
      .cmp_in     (cmp_in),
      .dac_drive  (dac_drive),
      .sar_dac    (sar_dac),
      .sample     (sample),
      .q_measured (q_measured),
      .ready      (ready)
   );

   function automatic int plant(input int i);
      return (i >> 1) + 50;
   endfunction

   function automatic logic [BW-1:0] held_next(
      input int m, input int l, input int k, input logic [BW-1:0] dd
   );
      if (m == M_RAMP) return BW'(l + (k % 4));
      if (m == M_PLANT) return BW'(plant(int'(dd)));
      return BW'(l);
   endfunction

   // Track/hold model: the value is held on the edge that ends SAMPLE.
   always @(posedge clk) begin
      if (rst) begin
         idx  <= 0;
         held <= '0;
      end else if (sample) begin
         held <= held_next(mode, lvl, idx, dac_drive);
         idx  <= idx + 1;
      end
   end

   always_comb begin
      cmp_in = 1'b0;
      case (mode)
         M_ONE:   cmp_in = 1'b1;
         M_ZERO:  cmp_in = 1'b0;
         default: cmp_in = (held >= sar_dac);
      endcase
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string t);
      chk({t, "_dac_drive"}, int'(dac_drive), 0);
      chk({t, "_sar_dac"}, int'(sar_dac), 0);
      chk({t, "_sample"}, int'(sample), 0);
      chk({t, "_q"}, int'(q_measured), 0);
      chk({t, "_ready"}, int'(ready), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for ready (bounded), then pops and checks the scoreboard.
   task automatic wait_ready(input int n0, output int n);
      bit seen;
      seen = 1'b0;
      n = n0;
      while (!seen && n < n0 + 400) begin
         @(negedge clk);
         n++;
         if (ready) seen = 1'b1;
      end
      chk("ready_seen", int'(seen), 1);
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) chk("q_measured", int'(q_measured), sb.pop_front());
   endtask

   task automatic watch(input int cyc, output int pulses, output int samp);
      pulses = 0;
      samp = 0;
      repeat (cyc) begin
         @(negedge clk);
         pulses += int'(ready);
         samp += int'(sample);
      end
   endtask

   initial begin
      int n;
      int pulses;
      int samp;
      int lat;
      bit seen;
      int ip, qp, ic, qc, inext;
      bit conv;

      lat = meas_latency(BW, ST, AL);
      rst = 1'b1;
      en = 1'b0;
      i_ref = '0;
      repeat (3) @(negedge clk);
      chk_outs("rst0");
      rst = 1'b0;

      // Reset mid-CONVERT aborts the measurement
      mode = M_LEVEL;
      lvl = 512;
      i_ref = 10'd300;
      en = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (sample) seen = 1'b1;
      end
      chk("t1_sample_seen", int'(seen), 1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_outs("t1");
      rst = 1'b0;
      en = 1'b0;
      watch(120, pulses, samp);
      chk("t1_no_ready", pulses, 0);
      chk("t1_no_sample", samp, 0);

      // Latency, dac_drive capture, i_ref ignored outside APPLY
      lvl = 512;
      i_ref = 10'd300;
      sb.push_back(512);
      en = 1'b1;
      repeat (5) @(negedge clk);
      i_ref = 10'd777;
      wait_ready(5, n);
      chk("t2_latency", n, lat);
      chk("t2_dac_drive", int'(dac_drive), 300);
      en = 1'b0;
      @(negedge clk);
      chk("t2_ready_one_cycle", int'(ready), 0);
      chk("t2_q_hold", int'(q_measured), 512);

      // Averaging of 100,101,102,103
      do_reset();
      mode = M_RAMP;
      lvl = 100;
      sb.push_back(101);
      en = 1'b1;
      wait_ready(0, n);
      en = 1'b0;
      watch(100, pulses, samp);
      chk("t3_single_ready", pulses, 0);
      chk("t3_q_hold", int'(q_measured), 101);

      // Comparator extremes, back to back
      mode = M_ONE;
      sb.push_back(1023);
      en = 1'b1;
      wait_ready(0, n);
      mode = M_ZERO;
      sb.push_back(0);
      wait_ready(0, n);
      chk("t4_b2b_latency", n, lat);
      en = 1'b0;

      // en dropped during SETTLE
      @(negedge clk);
      mode = M_LEVEL;
      lvl = 700;
      i_ref = 10'd5;
      sb.push_back(700);
      en = 1'b1;
      repeat (8) @(negedge clk);
      en = 1'b0;
      wait_ready(8, n);
      chk("t5_latency", n, lat);
      watch(100, pulses, samp);
      chk("t5_no_ready", pulses, 0);
      chk("t5_no_sample", samp, 0);
      chk("t5_q_hold", int'(q_measured), 700);
      chk("t5_dac_hold", int'(dac_drive), 5);

      // Closed loop with a secant controller, target 258
      do_reset();
      mode = M_PLANT;
      conv = 1'b0;
      ip = 0;
      qp = 0;
      ic = 100;
      i_ref = BW'(ic);
      sb.push_back(plant(ic));
      en = 1'b1;
      for (int m = 0; m < 20 && !conv; m++) begin
         wait_ready(0, n);
         chk("t6_apply_iref", int'(dac_drive), ic);
         qc = int'(q_measured);
         if (qc == 258) conv = 1'b1;
         if (m == 0) inext = 200;
         else if (qc == qp) inext = ic;
         else inext = ic + (258 - qc) * (ic - ip) / (qc - qp);
         if (inext < 0) inext = 0;
         if (inext > 1023) inext = 1023;
         ip = ic;
         qp = qc;
         ic = inext;
         if (conv) begin
            en = 1'b0;
         end else begin
            i_ref = BW'(ic);
            sb.push_back(plant(ic));
         end
      end
      chk("t6_converged", int'(conv), 1);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
